// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register pending-write scoreboard; reads are 1-cycle registered,
// write-first bypass, no backpressure (every request is serviced). ZERO_REG_EN hardwires register 0 to zero.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NRP    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRP-1:0]        rd_en,
   input  logic [NRP*ADDR_W-1:0] rd_addr,
   output logic [NRP*DATA_W-1:0] rd_data,
   output logic [NRP-1:0]        rd_busy,
   output logic [NRP-1:0]        rd_valid,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic                  rsv_err,
   input  logic [ADDR_W-1:0]     probe_addr,
   output logic [DATA_W-1:0]     probe_data
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   // An address is usable when it maps to a real, writable register.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_L;
   endfunction

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
`ifdef ZERO_REG_EN
      return in_range(a) && (a != '0);
`else
      return in_range(a);
`endif
   endfunction

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              wr_ok;
   logic              rsv_ok;
   logic              rsv_err_nxt;

   assign wr_ok  = wr_en  & addr_ok(wr_addr);
   assign rsv_ok = rsv_en & addr_ok(rsv_addr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Reservation is ordered after the write clear so a same-address reserve wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= '0;
      end else begin
         if (wr_ok)  pend[wr_addr]  <= 1'b0;
         if (rsv_ok) pend[rsv_addr] <= 1'b1;
      end
   end

   assign rsv_err_nxt = rsv_ok & pend[rsv_addr] & ~(wr_ok & (wr_addr == rsv_addr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rsv_err <= 1'b0;
      else      rsv_err <= rsv_err_nxt;
   end

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              ok;
      logic              hit;
      logic [DATA_W-1:0] d_nxt;
      logic              b_nxt;
      logic [DATA_W-1:0] d_q;
      logic              b_q;
      logic              v_q;

      assign a   = rd_addr[p*ADDR_W +: ADDR_W];
      assign ok  = addr_ok(a);
      assign hit = wr_ok & (wr_addr == a);

      // Write-first: a same-cycle write supplies the data and hides the pending bit it clears.
      always_comb begin
         d_nxt = '0;
         b_nxt = 1'b0;
         if (ok) begin
            if (hit) begin
               d_nxt = wr_data;
            end else begin
               d_nxt = regs[a];
               b_nxt = pend[a];
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            d_q <= '0;
            b_q <= 1'b0;
            v_q <= 1'b0;
         end else begin
            v_q <= rd_en[p];
            if (rd_en[p]) begin
               d_q <= d_nxt;
               b_q <= b_nxt;
            end
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = d_q;
      assign rd_busy[p]                  = b_q;
      assign rd_valid[p]                 = v_q;
   end

   // Register 0 is never written when hardwired, so stored contents already read as zero.
   assign probe_data = in_range(probe_addr) ? regs[probe_addr] : '0;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised + directed bench for regfile_scoreboard against an array-based behavioural model.
module tb_regfile_scoreboard;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int NRP    = 2;
`ifdef ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NRP-1:0]        rd_en;
   logic [NRP*ADDR_W-1:0] rd_addr;
   logic [NRP*DATA_W-1:0] rd_data;
   logic [NRP-1:0]        rd_busy;
   logic [NRP-1:0]        rd_valid;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  rsv_en;
   logic [ADDR_W-1:0]     rsv_addr;
   logic                  rsv_err;
   logic [ADDR_W-1:0]     probe_addr;
   logic [DATA_W-1:0]     probe_data;

   regfile_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRP(NRP)) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
      .probe_addr(probe_addr), .probe_data(probe_data)
   );

   always #5 clk = ~clk;

   // Behavioural model: architectural register contents, pending set, expected output registers.
   logic [DATA_W-1:0] m_regs [DEPTH];
   bit                m_pend [DEPTH];
   logic [DATA_W-1:0] exp_data [NRP];
   bit                exp_busy [NRP];
   bit                exp_valid [NRP];
   bit                exp_err;
   bit                chk_en = 1'b0;
   int                vectors = 0;
   int                miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit usable(input int a);
      return (a < DEPTH) && !(ZR && a == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = DATA_W'(i);
         m_pend[i] = 1'b0;
      end
      for (int p = 0; p < NRP; p++) begin
         exp_data[p]  = '0;
         exp_busy[p]  = 1'b0;
         exp_valid[p] = 1'b0;
      end
      exp_err = 1'b0;
   endtask

   task automatic model_update();
      int w, r, a;
      w = int'(wr_addr);
      r = int'(rsv_addr);
      for (int p = 0; p < NRP; p++) begin
         exp_valid[p] = rd_en[p];
         if (rd_en[p]) begin
            a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
            if (!usable(a)) begin
               exp_data[p] = '0;
               exp_busy[p] = 1'b0;
            end else if (wr_en && w == a) begin
               exp_data[p] = wr_data;
               exp_busy[p] = 1'b0;
            end else begin
               exp_data[p] = m_regs[a];
               exp_busy[p] = m_pend[a];
            end
         end
      end
      exp_err = rsv_en && usable(r) && m_pend[r] && !(wr_en && w == r);
      if (wr_en && usable(w)) begin
         m_regs[w] = wr_data;
         m_pend[w] = 1'b0;
      end
      if (rsv_en && usable(r)) m_pend[r] = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_update();
      #1;
   endtask

   task automatic idle();
      rd_en  = '0;
      wr_en  = 1'b0;
      rsv_en = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
      return ADDR_W'($urandom_range(0, DEPTH - 1));
   endfunction

   task automatic rand_inputs();
      rd_en = NRP'($urandom);
      for (int p = 0; p < NRP; p++) rd_addr[p*ADDR_W +: ADDR_W] = rand_addr();
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = rand_addr();
      wr_data    = DATA_W'($urandom);
      rsv_en     = ($urandom_range(0, 2) == 0);
      rsv_addr   = rand_addr();
      probe_addr = rand_addr();
   endtask

   task automatic rd(input int p, input int a);
      rd_en[p] = 1'b1;
      rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   // Single compare process: every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int p = 0; p < NRP; p++) begin
            chk($sformatf("rd_valid%0d", p), rd_valid[p], exp_valid[p]);
            chk($sformatf("rd_data%0d", p), rd_data[p*DATA_W +: DATA_W], exp_data[p]);
            chk($sformatf("rd_busy%0d", p), rd_busy[p], exp_busy[p]);
         end
         chk("rsv_err", rsv_err, exp_err);
         chk("probe_data", probe_data, m_regs[int'(probe_addr)]);
      end
   end

   initial begin
      rst = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0; probe_addr = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      probe_addr = ADDR_W'(9);
      #1;
      chk("reset_valid", rd_valid, 0);
      chk("reset_data", rd_data, 0);
      chk("reset_err", rsv_err, 0);
      chk("reset_probe9", probe_data, 9);

      // Reset contents are the register index.
      rd(0, 5); rd(1, 31);
      step(); idle();
      chk("t1_valid", rd_valid, 2'b11);
      chk("t1_data0", rd_data[DATA_W-1:0], 5);
      chk("t1_data1", rd_data[2*DATA_W-1:DATA_W], 31);
      chk("t1_busy", rd_busy, 0);

      // Write-first bypass; probe shows the pre-write value.
      wr_en = 1'b1; wr_addr = ADDR_W'(7); wr_data = 32'hDEADBEEF; rd(0, 7); probe_addr = ADDR_W'(7);
      #1 chk("t2_probe_pre", probe_data, 7);
      step(); idle();
      chk("t2_bypass", rd_data[DATA_W-1:0], 32'hDEADBEEF);
      chk("t2_probe_post", probe_data, 32'hDEADBEEF);

      rsv_en = 1'b1; rsv_addr = ADDR_W'(3);
      step(); idle();
      rd(0, 3);
      step(); idle();
      chk("t3_busy", rd_busy[0], 1);
      wr_en = 1'b1; wr_addr = ADDR_W'(3); wr_data = 32'h1234; rd(0, 3);
      step(); idle();
      chk("t3_busy_clr", rd_busy[0], 0);
      chk("t3_data", rd_data[DATA_W-1:0], 32'h1234);

      rsv_en = 1'b1; rsv_addr = ADDR_W'(4);
      step();
      chk("t4_err_first", rsv_err, 0);
      step(); idle();
      chk("t4_err_second", rsv_err, 1);
      step();
      chk("t4_err_pulse", rsv_err, 0);
      wr_en = 1'b1; wr_addr = ADDR_W'(4); wr_data = 32'h44;
      step();
      rsv_en = 1'b1; rsv_addr = ADDR_W'(4);
      step(); idle();
      chk("t4_rsv_wr_err", rsv_err, 0);
      rd(0, 4);
      step(); idle();
      chk("t4_rsv_wins", rd_busy[0], 1);

`ifdef ZERO_REG_EN
      wr_en = 1'b1; wr_addr = '0; wr_data = 32'h55; rd(1, 0);
      step(); idle();
      chk("t6_bypass0", rd_data[2*DATA_W-1:DATA_W], 0);
      rd(0, 0);
      step(); idle();
      chk("t6_read0", rd_data[DATA_W-1:0], 0);
      rsv_en = 1'b1; rsv_addr = '0;
      step();
      step(); idle();
      chk("t6_err0", rsv_err, 0);
      rd(0, 0);
      step(); idle();
      chk("t6_busy0", rd_busy[0], 0);
`endif

      repeat (500) begin
         rand_inputs();
         step();
      end

      // Reset mid-burst with reads in flight.
      repeat (3) begin
         rand_inputs();
         rd_en = '1;
         step();
      end
      rst = 1'b0;
      model_reset();
      probe_addr = ADDR_W'(7);
      #1;
      chk("t5_valid", rd_valid, 0);
      chk("t5_data", rd_data, 0);
      chk("t5_busy", rd_busy, 0);
      chk("t5_err", rsv_err, 0);
      chk("t5_probe7", probe_data, ZR ? 7 : 7);
      step();
      rst = 1'b1;
      idle();
      rd(0, 4); rd(1, 7);
      step(); idle();
      chk("t5_pend_clr", rd_busy, 0);
      chk("t5_reg7", rd_data[2*DATA_W-1:DATA_W], 7);

      repeat (400) begin
         rand_inputs();
         step();
      end
      idle();
      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
